cdb_arbiter: RTL and testbench

- Consumer/driver end of the Common Data Bus (CDB) broadcast protocol in the Tomasulo core.
- Accepts completion requests from up to N_SRC functional-unit reservation stations (ALU, MUL, DIV, LOAD).
- Grants exactly one per cycle by round-robin and drives the registered CDB (tag, value, ICC flags) for one cycle.
- Returns a one-cycle ack to the winner so it can free its entry.

---
 rtl/tomasulo_pkg.sv | 32 +++
 rtl/cdb_arbiter_rr_pick.sv | 30 +++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants: CDB widths, reserved tag, source indices and ICC layout.
package tomasulo_pkg;

    localparam int TAG_W = 5;
    localparam int VAL_W = 32;
    localparam int N_SRC = 4;

    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

    localparam int SRC_ALU  = 0;
    localparam int SRC_MUL  = 1;
    localparam int SRC_DIV  = 2;
    localparam int SRC_LOAD = 3;

    // ICC bit positions within the 4-bit {c,v,z,n} field
    localparam int ICC_C = 3;
    localparam int ICC_V = 2;
    localparam int ICC_Z = 1;
    localparam int ICC_N = 0;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } icc_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible index at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!any && elig[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus driver: round-robin grant of one completing reservation station per
// cycle, registered broadcast of its tag/value/ICC and a same-cycle ack back to it.
module cdb_arbiter #(
    parameter int               N_SRC       = tomasulo_pkg::N_SRC,
    parameter int               TAG_W       = tomasulo_pkg::TAG_W,
    parameter int               VAL_W       = tomasulo_pkg::VAL_W,
    parameter logic [TAG_W-1:0] INVALID_TAG = TAG_W'(tomasulo_pkg::INVALID_TAG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       in_req,
    input  logic [N_SRC*TAG_W-1:0] in_tag,
    input  logic [N_SRC*VAL_W-1:0] in_val,
    input  logic [N_SRC*4-1:0]     in_icc,
    input  logic [N_SRC-1:0]       in_icc_we,
    output logic [N_SRC-1:0]       out_ack,
    output logic                   out_CDB_broadcast,
    output logic [TAG_W-1:0]       out_CDB_tag,
    output logic [VAL_W-1:0]       out_CDB_val,
    output logic [3:0]             out_ICC_flags,
    output logic                   out_ICC_we,
    output logic                   out_bad_tag
);

    import tomasulo_pkg::*;

    localparam int PW = $clog2(N_SRC);

    logic [N_SRC-1:0] elig_p0;
    logic [N_SRC-1:0] grant_p0;
    logic [PW-1:0]    win_p0;
    logic             any_p0;
    logic [TAG_W-1:0] win_tag_p0;
    logic             win_bad_p0;

    logic [PW-1:0]    rr_ptr;
    logic [N_SRC-1:0] ack_p1;
    logic             vld_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [VAL_W-1:0] val_p1;
    icc_t             icc_p1;
    logic             icc_we_p1;
    logic             bad_p1;

    // Stage p0: mask sources acked last cycle so a held request is not granted twice
    assign elig_p0 = in_req & ~ack_p1;

    rr_pick #(
        .N  (N_SRC),
        .PW (PW)
    ) u_rr_pick (
        .elig  (elig_p0),
        .ptr   (rr_ptr),
        .grant (grant_p0),
        .idx   (win_p0),
        .any   (any_p0)
    );

    assign win_tag_p0 = in_tag[int'(win_p0)*TAG_W +: TAG_W];
    assign win_bad_p0 = (win_tag_p0 == INVALID_TAG);

    // Stage p1: registered CDB, ack and sticky bad-tag flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            ack_p1    <= '0;
            vld_p1    <= 1'b0;
            icc_we_p1 <= 1'b0;
            bad_p1    <= 1'b0;
            tag_p1    <= '0;
            val_p1    <= '0;
            icc_p1    <= '0;
        end else begin
            ack_p1    <= grant_p0;
            vld_p1    <= any_p0 && !win_bad_p0;
            icc_we_p1 <= any_p0 && !win_bad_p0 && in_icc_we[win_p0];
            if (any_p0) begin
                rr_ptr <= PW'(rr_next(int'(win_p0), N_SRC));
            end
            if (any_p0 && win_bad_p0) begin
                bad_p1 <= 1'b1;
            end
            // Data only moves on a real broadcast; it is don't-care otherwise
            if (any_p0 && !win_bad_p0) begin
                tag_p1 <= win_tag_p0;
                val_p1 <= in_val[int'(win_p0)*VAL_W +: VAL_W];
                icc_p1 <= icc_t'(in_icc[int'(win_p0)*4 +: 4]);
            end
        end
    end

    assign out_ack           = ack_p1;
    assign out_CDB_broadcast = vld_p1;
    assign out_CDB_tag       = tag_p1;
    assign out_CDB_val       = val_p1;
    assign out_ICC_flags     = icc_p1;
    assign out_ICC_we        = icc_we_p1;
    assign out_bad_tag       = bad_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run
// compared against a queue-free behavioural model of the round-robin CDB.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int VW = 32;
    localparam logic [TW-1:0] BAD = 5'b11111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    icc_we_v;
    logic [TW-1:0]   tag [N];
    logic [VW-1:0]   val [N];
    logic [3:0]      icc [N];

    logic [N*TW-1:0] in_tag;
    logic [N*VW-1:0] in_val;
    logic [N*4-1:0]  in_icc;

    logic [N-1:0]    out_ack;
    logic            out_CDB_broadcast;
    logic [TW-1:0]   out_CDB_tag;
    logic [VW-1:0]   out_CDB_val;
    logic [3:0]      out_ICC_flags;
    logic            out_ICC_we;
    logic            out_bad_tag;

    always_comb begin
        in_tag = '0;
        in_val = '0;
        in_icc = '0;
        for (int i = 0; i < N; i++) begin
            in_tag[i*TW +: TW] = tag[i];
            in_val[i*VW +: VW] = val[i];
            in_icc[i*4 +: 4]   = icc[i];
        end
    end

    cdb_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .in_req            (req),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .in_icc            (in_icc),
        .in_icc_we         (icc_we_v),
        .out_ack           (out_ack),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_ICC_flags     (out_ICC_flags),
        .out_ICC_we        (out_ICC_we),
        .out_bad_tag       (out_bad_tag)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [N+TW+VW+7-1:0] all_out;
        rst = 1'b1;
        req = '1;
        for (int i = 0; i < N; i++) begin
            tag[i] = TW'(i * 3 + 1);
            val[i] = 32'hA000_0000 + i;
            icc[i] = 4'hF;
            icc_we_v[i] = 1'b1;
        end
        tick();
        tick();
        all_out = {out_ack, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
                   out_ICC_flags, out_ICC_we, out_bad_tag};
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (out_ack !== 4'b0001 || out_CDB_broadcast !== 1'b1 || out_CDB_tag !== 5'd1)
            $display("FAIL reset_first_grant got ack=%b bc=%b tag=%0d want ack=0001 bc=1 tag=1",
                     out_ack, out_CDB_broadcast, out_CDB_tag);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        tag[1] = 5'd6;
        val[1] = 32'h0000_0F00;
        icc[1] = 4'b0000;
        icc_we_v[1] = 1'b1;
        tick();
        n_checks++;
        if (out_ack !== 4'b0010 || out_CDB_broadcast !== 1'b1 || out_CDB_tag !== 5'd6 ||
            out_CDB_val !== 32'h0000_0F00 || out_ICC_we !== 1'b1 || out_ICC_flags !== 4'b0000)
            $display("FAIL single_grant got ack=%b bc=%b tag=%0d val=%h we=%b icc=%b want 0010 1 6 00000f00 1 0000",
                     out_ack, out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_we, out_ICC_flags);
        else n_pass++;
        req = 4'b0000;
        tick();
        n_checks++;
        if (out_ack !== 4'b0000 || out_CDB_broadcast !== 1'b0 || out_ICC_we !== 1'b0)
            $display("FAIL single_no_repeat got ack=%b bc=%b we=%b want 0000 0 0",
                     out_ack, out_CDB_broadcast, out_ICC_we);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [TW-1:0] tags [N];
        tags[0] = 5'd0; tags[1] = 5'd5; tags[2] = 5'd9; tags[3] = 5'd12;
        do_reset();
        for (int i = 0; i < N; i++) begin
            tag[i] = tags[i];
            val[i] = 32'h100 * (i + 1);
            icc_we_v[i] = 1'b0;
        end
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++;
            if (out_ack !== 4'(1 << k) || out_CDB_broadcast !== 1'b1 || out_CDB_tag !== tags[k] ||
                out_ICC_we !== 1'b0)
                $display("FAIL contention_%0d got ack=%b bc=%b tag=%0d we=%b want ack=%b bc=1 tag=%0d we=0",
                         k, out_ack, out_CDB_broadcast, out_CDB_tag, out_ICC_we, 4'(1 << k), tags[k]);
            else n_pass++;
            req[k] = 1'b0;
        end
        tick();
    endtask

    task automatic test_fairness();
        int exp_src;
        logic [TW-1:0] exp_tag;
        do_reset();
        tag[0] = 5'd1;  val[0] = 32'h11; icc_we_v[0] = 1'b0;
        tag[2] = 5'd20; val[2] = 32'h22; icc_we_v[2] = 1'b0;
        req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            exp_src = (k % 2 == 0) ? 0 : 2;
            exp_tag = (k % 2 == 0) ? TW'(1 + k / 2) : TW'(20 + k / 2);
            tick();
            n_checks++;
            if (out_ack !== 4'(1 << exp_src) || out_CDB_broadcast !== 1'b1 || out_CDB_tag !== exp_tag)
                $display("FAIL fairness_%0d got ack=%b bc=%b tag=%0d want ack=%b bc=1 tag=%0d",
                         k, out_ack, out_CDB_broadcast, out_CDB_tag, 4'(1 << exp_src), exp_tag);
            else n_pass++;
            for (int i = 0; i < N; i++) begin
                if (out_ack[i]) tag[i] = tag[i] + 5'd1;
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_bad_tag();
        do_reset();
        req = 4'b1000;
        tag[3] = BAD;
        icc_we_v[3] = 1'b1;
        tick();
        n_checks++;
        if (out_ack !== 4'b1000 || out_CDB_broadcast !== 1'b0 || out_ICC_we !== 1'b0 || out_bad_tag !== 1'b1)
            $display("FAIL bad_tag_grant got ack=%b bc=%b we=%b bad=%b want 1000 0 0 1",
                     out_ack, out_CDB_broadcast, out_ICC_we, out_bad_tag);
        else n_pass++;
        req = 4'b0010;
        tag[1] = 5'd4;
        val[1] = 32'hCAFE;
        icc_we_v[1] = 1'b0;
        tick();
        n_checks++;
        if (out_ack !== 4'b0010 || out_CDB_broadcast !== 1'b1 || out_CDB_tag !== 5'd4 || out_bad_tag !== 1'b1)
            $display("FAIL bad_tag_sticky got ack=%b bc=%b tag=%0d bad=%b want 0010 1 4 1",
                     out_ack, out_CDB_broadcast, out_CDB_tag, out_bad_tag);
        else n_pass++;
        req = '0;
        tick();
        tick();
        n_checks++;
        if (out_bad_tag !== 1'b1)
            $display("FAIL bad_tag_hold got %b want 1", out_bad_tag);
        else n_pass++;
        do_reset();
        n_checks++;
        if (out_bad_tag !== 1'b0)
            $display("FAIL bad_tag_clear got %b want 0", out_bad_tag);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tag[1] = 5'd7; val[1] = 32'h7; icc_we_v[1] = 1'b0;
        tag[3] = 5'd9; val[3] = 32'h9; icc_we_v[3] = 1'b0;
        req = 4'b1010;
        tick();
        n_checks++;
        if (out_ack !== 4'b0010 || out_CDB_broadcast !== 1'b1)
            $display("FAIL mid_pre_grant got ack=%b bc=%b want 0010 1", out_ack, out_CDB_broadcast);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_ack !== 4'b0000 || out_CDB_broadcast !== 1'b0)
            $display("FAIL mid_killed got ack=%b bc=%b want 0000 0", out_ack, out_CDB_broadcast);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (out_ack !== 4'b0010 || out_CDB_tag !== 5'd7 || out_CDB_broadcast !== 1'b1)
            $display("FAIL mid_regrant1 got ack=%b tag=%0d bc=%b want 0010 7 1",
                     out_ack, out_CDB_tag, out_CDB_broadcast);
        else n_pass++;
        req[1] = 1'b0;
        tick();
        n_checks++;
        if (out_ack !== 4'b1000 || out_CDB_tag !== 5'd9 || out_CDB_broadcast !== 1'b1)
            $display("FAIL mid_regrant3 got ack=%b tag=%0d bc=%b want 1000 9 1",
                     out_ack, out_CDB_tag, out_CDB_broadcast);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic new_data(input int i);
        tag[i] = ($urandom_range(0, 39) == 0) ? BAD : TW'($urandom_range(0, 30));
        val[i] = $urandom;
        icc[i] = 4'($urandom_range(0, 15));
        icc_we_v[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_random();
        int            m_ptr;
        logic [N-1:0]  m_ack;
        logic          m_bad;
        logic [N-1:0]  elig;
        int            w;
        logic [N-1:0]  e_ack;
        logic          e_bc, e_we;
        logic [TW-1:0] e_tag;
        logic [VW-1:0] e_val;
        logic [3:0]    e_icc;
        int            waits [N];
        int            max_wait [N];
        int            errs;
        do_reset();
        m_ptr = 0; m_ack = '0; m_bad = 1'b0;
        e_tag = '0; e_val = '0; e_icc = '0;
        errs = 0;
        for (int i = 0; i < N; i++) begin
            waits[i] = 0;
            max_wait[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            elig = req & ~m_ack;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            e_ack = (w >= 0) ? 4'(1 << w) : 4'b0000;
            e_bc  = (w >= 0) && (tag[w] != BAD);
            e_we  = e_bc && icc_we_v[w];
            if (e_bc) begin
                e_tag = tag[w];
                e_val = val[w];
                e_icc = icc[w];
            end
            if (w >= 0 && tag[w] == BAD) m_bad = 1'b1;
            if (w >= 0) m_ptr = (w + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (e_ack[i] || !req[i]) waits[i] = 0;
                else waits[i]++;
                if (waits[i] > max_wait[i]) max_wait[i] = waits[i];
            end
            m_ack = e_ack;
            tick();
            n_checks++;
            if (out_ack !== e_ack || out_CDB_broadcast !== e_bc || out_ICC_we !== e_we ||
                out_bad_tag !== m_bad ||
                (e_bc && (out_CDB_tag !== e_tag || out_CDB_val !== e_val || out_ICC_flags !== e_icc))) begin
                if (errs < 10)
                    $display("FAIL random_c%0d got ack=%b bc=%b we=%b bad=%b tag=%0d val=%h icc=%b want ack=%b bc=%b we=%b bad=%b tag=%0d val=%h icc=%b",
                             cyc, out_ack, out_CDB_broadcast, out_ICC_we, out_bad_tag, out_CDB_tag,
                             out_CDB_val, out_ICC_flags, e_ack, e_bc, e_we, m_bad, e_tag, e_val, e_icc);
                errs++;
            end else n_pass++;
            for (int i = 0; i < N; i++) begin
                if (out_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else new_data(i);
                end else if (!req[i] && $urandom_range(0, 9) < 4) begin
                    req[i] = 1'b1;
                    new_data(i);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (max_wait[i] > N)
                $display("FAIL starvation_src%0d got wait=%0d want <=%0d", i, max_wait[i], N);
            else n_pass++;
        end
        req = '0;
        tick();
    endtask

    initial begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            tag[i] = '0;
            val[i] = '0;
            icc[i] = '0;
            icc_we_v[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_bad_tag();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
